// File: rtl/uart_rx_pkg.sv
// Shared definitions for the Hack UART receiver (and its transmitter counterpart).
// Both ends of the link use these so that they agree on the frame format and the
// default baud divisor.
// Contents:
//   DATA_BITS            payload bits per frame
//   CLKS_PER_BIT_DEFAULT 25 MHz / 115200 baud
//   uart_rx_state_e      receiver FSM state encoding (PARITY is used only when
//                        UART_RX_PARITY_EN is defined)
package uart_rx_pkg;

   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4,
      ST_PARITY  = 3'd5
   } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input (RX pin, buttons).
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset; both flops load RESET_VAL
//   d_i     asynchronous input
//   q_o     synchronised output, two clk_i cycles of latency
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   // Shift chain: sync_q[0] may go metastable, sync_q[1] is safe to use.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Hack UART receiver: deserialises 8N1 frames from the RX pin into a Hack word
// {8'h00, byte} and presents it on the memory-mapped IO bus with valid/ack.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit to the frame
// and a sticky PARITY_ERR output; a byte with bad parity is dropped.
// Ports:
//   CLK        system clock, rising edge
//   RESET_N    asynchronous active-low reset
//   RX         serial line, idle high, asynchronous to CLK
//   OUT        received word {0, data[7:0]}
//   VALID      OUT holds an unacknowledged byte
//   ACK        one-cycle read pulse; clears VALID and the sticky flags (only while VALID)
//   OVERRUN    sticky: a byte was overwritten before ACK
//   FRAME_ERR  sticky: stop bit sampled low
//   PARITY_ERR sticky: parity mismatch (UART_RX_PARITY_EN only)
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned BITS         = 16
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            RX,
   output logic [BITS-1:0] OUT,
   output logic            VALID,
   input  logic            ACK,
   output logic            OVERRUN,
   output logic            FRAME_ERR
`ifdef UART_RX_PARITY_EN
   ,
   output logic            PARITY_ERR
`endif
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic rx_s;

   uart_rx_state_e          state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0]    shift_q, shift_d;
   logic [DATA_BITS-1:0]    data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    ovr_q, ovr_d;
   logic                    ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                    perr_q, perr_d;
   logic                    pbad_q, pbad_d;
`endif

   logic byte_done;
   logic ferr_set;
   logic perr_set;
   logic ack_eff;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .clk_i  (CLK),
      .rst_ni (RESET_N),
      .d_i    (RX),
      .q_o    (rx_s)
   );

   // Next-state, datapath and handshake logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
      perr_d    = perr_q;
      pbad_d    = pbad_q;
`endif
      byte_done = 1'b0;
      ferr_set  = 1'b0;
      perr_set  = 1'b0;
      ack_eff   = ACK && valid_q;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
               pbad_d  = 1'b0;
`endif
            end
         end

         // Re-check the start bit at its centre; a short glitch returns to IDLE.
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // One sample per bit time, LSB first.
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         // Even parity: data bits plus parity bit must hold an even number of ones.
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_STOP;
               if (^{shift_q, rx_s}) begin
                  pbad_d   = 1'b1;
                  perr_set = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d   = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  byte_done = !pbad_q;
`else
                  byte_done = 1'b1;
`endif
               end else begin
                  state_d  = ST_RECOVER;
                  ferr_set = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Wait out a break so a held-low line does not start a new frame.
         ST_RECOVER: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // ACK clears first so that a same-cycle byte or flag set takes precedence.
      if (ack_eff) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
         ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_d  = 1'b0;
`endif
      end
      if (byte_done) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         if (valid_q && !ack_eff) begin
            ovr_d = 1'b1;
         end
      end
      if (ferr_set) begin
         ferr_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (perr_set) begin
         perr_d = 1'b1;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
         pbad_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
         pbad_q  <= pbad_d;
`endif
      end
   end

   assign OUT       = BITS'(data_q);
   assign VALID     = valid_q;
   assign OVERRUN   = ovr_q;
   assign FRAME_ERR = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign PARITY_ERR = perr_q;
`endif

endmodule
